// File: rtl/afu_flr_seq_pkg.sv
// Shared types and default widths for the per-port FLR reset sequencer.
package afu_flr_seq_pkg;

    localparam int FLR_PF_W           = 3;
    localparam int FLR_VF_W           = 11;
    localparam int FLR_REQ_FIFO_DEPTH = 4;
    localparam int FLR_RST_CYCLES     = 16;
    localparam int FLR_CNT_W          = 16;
    localparam int FLR_DRAIN_TIMEOUT  = 32'h0000_FFFF;

    typedef struct packed {
        logic [FLR_PF_W-1:0] pf;
        logic [FLR_VF_W-1:0] vf;
        logic                vf_active;
    } t_flr_func;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        DRAIN  = 2'd2,
        RESP   = 2'd3
    } t_flr_seq_state;

endpackage

// File: rtl/afu_flr_req_fifo.sv
// Pending-FLR queue: synchronous show-ahead FIFO, head valid whenever empty=0.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none; a push while full is ignored unless a pop frees a slot that cycle.
import afu_flr_seq_pkg::*;

module afu_flr_req_fifo #(
    parameter int  DEPTH = FLR_REQ_FIFO_DEPTH,
    parameter type T     = t_flr_func
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  T     push_dat,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Extra pointer MSB distinguishes full (wrapped) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/afu_flr_rst_seq.sv
// Per-port FLR sequencer: queued FLR request -> function soft reset -> drain -> completion.
// Latency: reset asserts 2 cycles after request; completion RST_CYCLES+3 cycles later if quiesced.
// Backpressure: none; requests into a full queue are dropped and flagged in err_overflow.
// Optional drain timeout: define AFU_FLR_DRAIN_TIMEOUT_EN.
import afu_flr_seq_pkg::*;

module afu_flr_rst_seq #(
    parameter int PF_W           = FLR_PF_W,
    parameter int VF_W           = FLR_VF_W,
    parameter int REQ_FIFO_DEPTH = FLR_REQ_FIFO_DEPTH,
    parameter int RST_CYCLES     = FLR_RST_CYCLES,
    parameter int CNT_W          = FLR_CNT_W,
    parameter int DRAIN_TIMEOUT  = FLR_DRAIN_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flr_req_valid,
    input  logic [PF_W-1:0] flr_req_pf,
    input  logic [VF_W-1:0] flr_req_vf,
    input  logic            flr_req_vf_active,
    output logic            flr_rsp_valid,
    output logic [PF_W-1:0] flr_rsp_pf,
    output logic [VF_W-1:0] flr_rsp_vf,
    output logic            flr_rsp_vf_active,
    output logic            func_rst_n,
    output logic [PF_W-1:0] func_pf,
    output logic [VF_W-1:0] func_vf,
    output logic            func_vf_active,
    input  logic            func_quiesced,
    output logic            busy,
    output logic            err_overflow,
    output logic            err_timeout
);

    typedef struct packed {
        logic [PF_W-1:0] pf;
        logic [VF_W-1:0] vf;
        logic            vf_active;
    } t_port_func;

    localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(RST_CYCLES - 1);

    t_flr_seq_state   state_q;
    t_flr_seq_state   state_d;
    logic [CNT_W-1:0] rst_cnt_q;
    t_port_func       func_q;
    t_port_func       req_func;
    t_port_func       fifo_head;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             req_drop;
    logic             drain_tmo;

    assign req_func = '{pf: flr_req_pf, vf: flr_req_vf, vf_active: flr_req_vf_active};

    afu_flr_req_fifo #(
        .DEPTH (REQ_FIFO_DEPTH),
        .T     (t_port_func)
    ) u_req_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (flr_req_valid),
        .push_dat (req_func),
        .pop      (fifo_pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    // A pop in the same cycle makes room, so only a full queue with no pop drops.
    assign req_drop = flr_req_valid & fifo_full & ~fifo_pop;

    always_comb begin
        state_d  = state_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ASSERT;
                end
            end
            ASSERT: begin
                if (rst_cnt_q == '0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (func_quiesced || drain_tmo) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rst_cnt_q    <= '0;
            func_q       <= '0;
            err_overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_pop) begin
                func_q    <= fifo_head;
                rst_cnt_q <= RST_LOAD;
            end else if ((state_q == ASSERT) && (rst_cnt_q != '0)) begin
                rst_cnt_q <= rst_cnt_q - CNT_W'(1);
            end
            if (req_drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

`ifdef AFU_FLR_DRAIN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(DRAIN_TIMEOUT);

    logic [CNT_W-1:0] drain_cnt_q;
    logic             err_timeout_q;

    // Counts DRAIN cycles from 0 and saturates; the limit forces the completion out.
    assign drain_tmo   = (state_q == DRAIN) && !func_quiesced && (drain_cnt_q >= TMO_LIM);
    assign err_timeout = err_timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt_q   <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            if (state_q != DRAIN) begin
                drain_cnt_q <= '0;
            end else if (drain_cnt_q != '1) begin
                drain_cnt_q <= drain_cnt_q + CNT_W'(1);
            end
            if (drain_tmo) begin
                err_timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_tmo_cfg;

    assign drain_tmo      = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_tmo_cfg = ^DRAIN_TIMEOUT;
`endif

    assign func_rst_n        = (state_q != ASSERT);
    assign flr_rsp_valid     = (state_q == RESP);
    assign flr_rsp_pf        = func_q.pf;
    assign flr_rsp_vf        = func_q.vf;
    assign flr_rsp_vf_active = func_q.vf_active;
    assign func_pf           = func_q.pf;
    assign func_vf           = func_q.vf;
    assign func_vf_active    = func_q.vf_active;
    assign busy              = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_afu_flr_rst_seq.sv
// Bench for afu_flr_rst_seq: timestamp-based job model checked every cycle plus directed scenarios.
module tb_afu_flr_rst_seq;

    localparam int PF_W  = 3;
    localparam int VF_W  = 11;
    localparam int DEPTH = 4;
    localparam int RST   = 16;
    localparam int CNT_W = 16;
    localparam int TMO   = 50;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flr_req_valid;
    logic [PF_W-1:0] flr_req_pf;
    logic [VF_W-1:0] flr_req_vf;
    logic            flr_req_vf_active;
    logic            flr_rsp_valid;
    logic [PF_W-1:0] flr_rsp_pf;
    logic [VF_W-1:0] flr_rsp_vf;
    logic            flr_rsp_vf_active;
    logic            func_rst_n;
    logic [PF_W-1:0] func_pf;
    logic [VF_W-1:0] func_vf;
    logic            func_vf_active;
    logic            func_quiesced;
    logic            busy;
    logic            err_overflow;
    logic            err_timeout;

    always #5 clk = ~clk;

    afu_flr_rst_seq #(
        .PF_W           (PF_W),
        .VF_W           (VF_W),
        .REQ_FIFO_DEPTH (DEPTH),
        .RST_CYCLES     (RST),
        .CNT_W          (CNT_W),
        .DRAIN_TIMEOUT  (TMO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flr_req_valid     (flr_req_valid),
        .flr_req_pf        (flr_req_pf),
        .flr_req_vf        (flr_req_vf),
        .flr_req_vf_active (flr_req_vf_active),
        .flr_rsp_valid     (flr_rsp_valid),
        .flr_rsp_pf        (flr_rsp_pf),
        .flr_rsp_vf        (flr_rsp_vf),
        .flr_rsp_vf_active (flr_rsp_vf_active),
        .func_rst_n        (func_rst_n),
        .func_pf           (func_pf),
        .func_vf           (func_vf),
        .func_vf_active    (func_vf_active),
        .func_quiesced     (func_quiesced),
        .busy              (busy),
        .err_overflow      (err_overflow),
        .err_timeout       (err_timeout)
    );

    typedef struct {
        int pf;
        int vf;
        int va;
    } job_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: pending jobs plus the active job described by the edge it started and the edge it responded.
    job_t mq[$];
    job_t m_cur;
    bit   m_active;
    int   m_pop_e;
    int   m_rsp_e;
    bit   m_ovf;
    bit   m_tmo;
    bit   s_rst;
    bit   s_req;
    bit   s_q;
    job_t s_f;

    int rsp_cyc[$];
    int rsp_vf[$];
    int rsp_pf[$];
    int low_cnt;
    int first_low;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit idle_before;
        int d0;
        if (!s_rst) begin
            mq.delete();
            m_active = 1'b0;
            m_cur    = '{0, 0, 0};
            m_ovf    = 1'b0;
            m_tmo    = 1'b0;
        end else begin
            idle_before = !m_active;
            if (m_active && m_rsp_e == cyc - 1) m_active = 1'b0;
            if (idle_before && mq.size() > 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_pop_e  = cyc;
                m_rsp_e  = -1;
            end
            if (s_req) begin
                if (mq.size() < DEPTH) mq.push_back(s_f);
                else m_ovf = 1'b1;
            end
            if (m_active && m_rsp_e < 0) begin
                d0 = m_pop_e + RST;
                if (cyc >= d0 + 1) begin
                    if (s_q) begin
                        m_rsp_e = cyc;
                    end
`ifdef AFU_FLR_DRAIN_TIMEOUT_EN
                    else if (cyc - d0 - 1 >= TMO) begin
                        m_rsp_e = cyc;
                        m_tmo   = 1'b1;
                    end
`endif
                end
            end
        end
    endtask

    initial begin
        m_active = 1'b0;
        m_cur    = '{0, 0, 0};
        m_ovf    = 1'b0;
        m_tmo    = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            s_rst = rst_n;
            s_req = flr_req_valid;
            s_q   = func_quiesced;
            s_f   = '{int'(flr_req_pf), int'(flr_req_vf), int'(flr_req_vf_active)};
            model_step();
            #1;
            chk("func_rst_n", func_rst_n, !(m_active && (cyc - m_pop_e < RST)));
            chk("rsp_valid", flr_rsp_valid, m_active && (m_rsp_e == cyc));
            chk("busy", busy, m_active || (mq.size() > 0));
            chk("err_overflow", err_overflow, m_ovf);
            chk("err_timeout", err_timeout, m_tmo);
            chk("func_pf", func_pf, m_cur.pf);
            chk("func_vf", func_vf, m_cur.vf);
            chk("func_vf_active", func_vf_active, m_cur.va);
            if (m_active && m_rsp_e == cyc) begin
                chk("rsp_pf", flr_rsp_pf, m_cur.pf);
                chk("rsp_vf", flr_rsp_vf, m_cur.vf);
                chk("rsp_vf_active", flr_rsp_vf_active, m_cur.va);
            end
            if (flr_rsp_valid === 1'b1) begin
                rsp_cyc.push_back(cyc);
                rsp_vf.push_back(int'(flr_rsp_vf));
                rsp_pf.push_back(int'(flr_rsp_pf));
            end
            if (func_rst_n === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        rsp_cyc.delete();
        rsp_vf.delete();
        rsp_pf.delete();
        low_cnt   = 0;
        first_low = -1;
    endtask

    task automatic send(input int pf, input int vf, input int va, output int req_cyc);
        req_cyc           = cyc;
        flr_req_valid     = 1'b1;
        flr_req_pf        = PF_W'(pf);
        flr_req_vf        = VF_W'(vf);
        flr_req_vf_active = va[0];
        tick(1);
        flr_req_valid     = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (rsp_cyc.size() < target && n < budget) begin
            tick(1);
            n++;
        end
        chk(name, rsp_cyc.size(), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int r;
        rst_n             = 1'b0;
        flr_req_valid     = 1'b0;
        flr_req_pf        = '0;
        flr_req_vf        = '0;
        flr_req_vf_active = 1'b0;
        func_quiesced     = 1'b1;
        clear_obs();
        tick(3);
        chk("reset_func_rst_n", func_rst_n, 1);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_valid", flr_rsp_valid, 0);
        chk("reset_err_overflow", err_overflow, 0);
        chk("reset_func_pf", func_pf, 0);
        rst_n = 1'b1;
        tick(2);

        // Single FLR
        clear_obs();
        send(1, 0, 0, k);
        wait_rsp(1, 60, "t1_rsp_count");
        chk("t1_rsp_latency", rsp_cyc[0] - k, 19);
        chk("t1_rsp_pf", rsp_pf[0], 1);
        chk("t1_low_start", first_low - k, 2);
        chk("t1_low_len", low_cnt, 16);
        tick(1);
        chk("t1_busy_after", busy, 0);
        tick(3);

        // Back-to-back
        clear_obs();
        send(0, 2, 1, k);
        send(0, 5, 1, k);
        send(0, 7, 1, k);
        wait_rsp(3, 200, "t2_rsp_count");
        chk("t2_order0", rsp_vf[0], 2);
        chk("t2_order1", rsp_vf[1], 5);
        chk("t2_order2", rsp_vf[2], 7);
        chk("t2_space01", rsp_cyc[1] - rsp_cyc[0], 19);
        chk("t2_space12", rsp_cyc[2] - rsp_cyc[1], 19);
        chk("t2_no_overflow", err_overflow, 0);
        tick(3);

        // Overflow
        clear_obs();
        func_quiesced = 1'b0;
        for (int i = 0; i < 6; i++) send(0, 10 + i, 1, k);
        tick(2);
        chk("t3_overflow", err_overflow, 1);
        tick(40);
        func_quiesced = 1'b1;
        wait_rsp(5, 300, "t3_rsp_count");
        tick(30);
        chk("t3_rsp_exact", rsp_cyc.size(), 5);
        chk("t3_last_vf", rsp_vf[4], 14);
        tick(2);

        // Drain stall
        clear_obs();
        func_quiesced = 1'b0;
        send(2, 3, 1, k);
        tick(17);
        tick(99);
        r = cyc;
        func_quiesced = 1'b1;
        wait_rsp(1, 20, "t4_rsp_count");
        chk("t4_rsp_after_quiesce", rsp_cyc[0] - r, 1);
        chk("t4_low_len", low_cnt, 16);
        tick(3);

        // Timeout / indefinite drain
        clear_obs();
        func_quiesced = 1'b0;
        send(4, 9, 1, k);
`ifdef AFU_FLR_DRAIN_TIMEOUT_EN
        wait_rsp(1, 120, "t5_rsp_count");
        chk("t5_tmo_latency", rsp_cyc[0] - k, 69);
        tick(1);
        chk("t5_err_timeout", err_timeout, 1);
`else
        tick(200);
        chk("t5_no_rsp", rsp_cyc.size(), 0);
        chk("t5_err_timeout", err_timeout, 0);
        chk("t5_busy_stuck", busy, 1);
`endif
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        func_quiesced = 1'b1;
        chk("t5_sticky_cleared", err_overflow, 0);
        tick(2);

        // Reset mid-ASSERT with two requests queued
        clear_obs();
        send(1, 1, 1, k);
        send(1, 2, 1, r);
        send(1, 3, 1, r);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        chk("t6_func_rst_n", func_rst_n, 1);
        chk("t6_busy", busy, 0);
        rst_n = 1'b1;
        tick(80);
        chk("t6_no_rsp", rsp_cyc.size(), 0);
        chk("t6_low_len", low_cnt, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
